cle_pin_deser: RTL and testbench
================================

Name: cle_pin_deser

Overview:
- Memory-side receiver for the CLE reduced-pin interface.
- The CLE core serialises ROM address, SRAM address and SRAM write data onto 1-bit pins, MSB first; a 2-bit dtype selects which field is on the wire.
- This block rebuilds the parallel fields, holds them stable for the ROM/SRAM macros and flags completed or aborted frames.
- It replaces the bench-side shift logic and sits between the CLE pins and rom_128x8 / sram_1024x8.

Parameters:
- RA_W, 7, ROM address width
- SA_W, 10, SRAM address width
- SD_W, 8, SRAM data width

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- dtype  input  2  field select: 0 idle, 1 ROM addr, 2 SRAM addr, 3 SRAM data
- rom_a_s  input  1  serial ROM address bit
- sram_a_s  input  1  serial SRAM address bit
- sram_d_s  input  1  serial SRAM data bit
- rom_a  output  RA_W  committed ROM address
- sram_a  output  SA_W  committed SRAM address
- sram_d  output  SD_W  committed SRAM write data
- rom_a_vld  output  1  1-cycle pulse: rom_a updated
- sram_a_vld  output  1  1-cycle pulse: sram_a updated
- sram_d_vld  output  1  1-cycle pulse: sram_d updated
- abort  output  1  1-cycle pulse: partial frame discarded

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, bit counter 0, shift register 0, all outputs 0.
- FSM states: IDLE, RX_RA, RX_SA, RX_SD.
  - Entry from any state on dtype = 1, 2 or 3 respectively.
  - dtype = 0 returns to IDLE.
- Sampling:
  - In the cycle dtype becomes non-zero, the selected pin is sampled immediately; the first bit is the MSB.
  - Each cycle with dtype unchanged and non-zero: shift_reg <= {shift_reg, bit} and increment the counter.
  - Only the pin matching dtype is sampled; the others are ignored.
- Commit:
  - When the counter reaches the field width, the shifted value is registered into the output on the next clock edge, together with a one-cycle valid pulse; latency is 1 cycle after the last bit.
  - The counter then clears. If dtype stays the same, the next frame starts on the next cycle, so back-to-back frames need no idle gap.
- Outputs hold their committed value until the next commit of the same field. They never show partial values.
- Abort:
  - Triggered when dtype changes (to 0 or to another field) while 0 < counter < width.
  - Partial bits are dropped, the output keeps its old value, and abort pulses for 1 cycle.
  - If the new dtype is non-zero, its first bit is sampled in the same cycle.
- Simultaneous events: a commit in the same cycle as a dtype change is a completed frame. The valid pulse fires and abort does not.
- Asynchronous reset in mid-frame discards everything. No valid or abort pulse is generated.
- Shift register and counter are sized for max(RA_W, SA_W, SD_W); the counter wraps to 0 only via commit or abort.

Optional Feature:
- Macro: CLE_DESER_ABORT_CNT_EN.
- Defined: adds output port abort_cnt [7:0].
  - Reset value 0.
  - Increments on each abort pulse and saturates at 255.
- Undefined: port and counter are absent; abort pulse behaviour is unchanged.

Decomposition:
- Package cle_pin_pkg holds:
  - dtype encodings DT_IDLE=0, DT_RA=1, DT_SA=2, DT_SD=3
  - default field widths
  - FSM state enum
- One natural sub-module, cle_ser_shift: a generic MSB-first shift register with bit counter and done/abort outputs, instantiated once with width max(RA_W, SA_W, SD_W). Field steering stays in the top.

Test Plan:
- dtype=1 for 7 cycles with bits 1,0,1,1,0,0,1 -> rom_a=7'h59 and one rom_a_vld pulse, 1 cycle after the 7th bit.
- dtype=2 for 20 cycles carrying 10'h3FF then 10'h001 -> two sram_a_vld pulses, 10 cycles apart; sram_a=3FF, then 001.
- dtype=3 for 4 bits, then dtype=0 -> abort pulse; sram_d keeps its previous 8'hA5; no sram_d_vld.
- dtype=3, 8 bits of 8'h3C, with dtype switching to 2 in the cycle after the 8th bit -> sram_d_vld fires, sram_d=3C, no abort; the SRAM-address frame starts cleanly.
- reset driven low mid-way through the 6th SRAM-address bit -> all outputs 0 immediately; after release, a full 10-bit frame of 10'h155 commits correctly.
- With CLE_DESER_ABORT_CNT_EN defined, 300 aborted frames -> abort_cnt=255.

Source files
------------

// File: rtl/cle_pin_pkg.sv
// Shared definitions for the CLE reduced-pin deserialiser.
//   - dtype encodings driven by the CLE core on its 2-bit field-select pins
//   - default field widths for the ROM address, SRAM address and SRAM data
//   - receiver FSM state encoding
//   - max3(): sizes the shared shift register for the widest field
package cle_pin_pkg;

    localparam int unsigned RA_W_DEF = 7;
    localparam int unsigned SA_W_DEF = 10;
    localparam int unsigned SD_W_DEF = 8;

    localparam logic [1:0] DT_IDLE = 2'd0;
    localparam logic [1:0] DT_RA   = 2'd1;
    localparam logic [1:0] DT_SA   = 2'd2;
    localparam logic [1:0] DT_SD   = 2'd3;

    // State values line up with the dtype that selects them.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRxRa = 2'd1,
        StRxSa = 2'd2,
        StRxSd = 2'd3
    } deser_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cle_pin_deser_if.sv
// Pin-side and macro-side signal bundle of the CLE deserialiser.
//   dtype      : field select (0 idle, 1 ROM addr, 2 SRAM addr, 3 SRAM data)
//   rom_a_s    : serial ROM address bit, MSB first
//   sram_a_s   : serial SRAM address bit, MSB first
//   sram_d_s   : serial SRAM write-data bit, MSB first
//   rom_a      : committed ROM address          rom_a_vld  : 1-cycle update pulse
//   sram_a     : committed SRAM address         sram_a_vld : 1-cycle update pulse
//   sram_d     : committed SRAM write data      sram_d_vld : 1-cycle update pulse
//   abort      : 1-cycle pulse, partial frame discarded
// Modports: master = CLE core / bench side, slave = deserialiser.
interface cle_pin_deser_if
    import cle_pin_pkg::*;
#(
    parameter int unsigned RA_W = RA_W_DEF,
    parameter int unsigned SA_W = SA_W_DEF,
    parameter int unsigned SD_W = SD_W_DEF
);
    logic [1:0]      dtype;
    logic            rom_a_s;
    logic            sram_a_s;
    logic            sram_d_s;
    logic [RA_W-1:0] rom_a;
    logic [SA_W-1:0] sram_a;
    logic [SD_W-1:0] sram_d;
    logic            rom_a_vld;
    logic            sram_a_vld;
    logic            sram_d_vld;
    logic            abort;

    modport master (
        output dtype, rom_a_s, sram_a_s, sram_d_s,
        input  rom_a, sram_a, sram_d, rom_a_vld, sram_a_vld, sram_d_vld, abort
    );

    modport slave (
        input  dtype, rom_a_s, sram_a_s, sram_d_s,
        output rom_a, sram_a, sram_d, rom_a_vld, sram_a_vld, sram_d_vld, abort
    );
endinterface

// File: rtl/cle_ser_shift.sv
// Generic MSB-first serial-to-parallel shifter with bit counter.
//   clk, reset : clock, asynchronous active-low reset
//   frame_len  : length of the frame currently being received
//   active     : a serial bit is present this cycle
//   field_chg  : the field select changed this cycle (ends any frame in progress)
//   bit_in     : serial data bit
//   data       : shift register; the frame sits right-justified when done is high
//   done       : counter has reached frame_len (frame complete)
//   abort      : frame in progress was broken before completion
// A new frame's first bit is loaded in the same cycle as done/abort so that
// back-to-back frames and immediate re-targeting need no idle cycle.
module cle_ser_shift #(
    parameter int unsigned Width = 10,
    parameter int unsigned CntW  = $clog2(Width + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CntW-1:0]  frame_len,
    input  logic             active,
    input  logic             field_chg,
    input  logic             bit_in,
    output logic [Width-1:0] data,
    output logic             done,
    output logic             abort
);
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Width-1:0] shift_q, shift_d;
    logic             frame_start;

    assign data  = shift_q;
    assign done  = (cnt_q != '0) && (cnt_q == frame_len);
    assign abort = field_chg && (cnt_q != '0) && !done;

    always_comb begin
        frame_start = done || field_chg || (cnt_q == '0);
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        if (active) begin
            if (frame_start) begin
                shift_d = {{(Width - 1){1'b0}}, bit_in};
                cnt_d   = CntW'(1);
            end else begin
                shift_d = {shift_q[Width-2:0], bit_in};
                cnt_d   = cnt_q + CntW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/cle_pin_deser.sv
// Memory-side receiver for the CLE reduced-pin interface. Rebuilds the ROM
// address, SRAM address and SRAM write data from their 1-bit pins, holds each
// committed value stable and pulses a per-field valid (or abort for a broken
// frame).
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   bus    : cle_pin_deser_if.slave (serial pins in, committed fields out)
//   abort_cnt [7:0] : saturating count of aborts, present only when
//                     CLE_DESER_ABORT_CNT_EN is defined
module cle_pin_deser
    import cle_pin_pkg::*;
#(
    parameter int unsigned RA_W = RA_W_DEF,
    parameter int unsigned SA_W = SA_W_DEF,
    parameter int unsigned SD_W = SD_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    cle_pin_deser_if.slave       bus
`ifdef CLE_DESER_ABORT_CNT_EN
    ,
    output logic [7:0]           abort_cnt
`endif
);
    localparam int unsigned MaxW = max3(RA_W, SA_W, SD_W);
    localparam int unsigned CntW = $clog2(MaxW + 1);

    deser_state_e    state_q, state_d;
    logic [CntW-1:0] frame_len;
    logic            ser_bit;
    logic            active;
    logic            field_chg;
    logic [MaxW-1:0] ser_data;
    logic            ser_done;
    logic            ser_abort;

    logic [RA_W-1:0] rom_a_q;
    logic [SA_W-1:0] sram_a_q;
    logic [SD_W-1:0] sram_d_q;
    logic            rom_a_vld_q, sram_a_vld_q, sram_d_vld_q, abort_q;

    // Next state depends only on dtype: any field can be entered from any state.
    always_comb begin
        state_d = StIdle;
        case (bus.dtype)
            DT_RA:   state_d = StRxRa;
            DT_SA:   state_d = StRxSa;
            DT_SD:   state_d = StRxSd;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame length follows the field in progress, not the incoming dtype, so
    // a completion coinciding with a dtype change is still seen.
    always_comb begin
        frame_len = CntW'(MaxW);
        case (state_q)
            StRxRa:  frame_len = CntW'(RA_W);
            StRxSa:  frame_len = CntW'(SA_W);
            StRxSd:  frame_len = CntW'(SD_W);
            default: frame_len = CntW'(MaxW);
        endcase
    end

    always_comb begin
        ser_bit = 1'b0;
        case (bus.dtype)
            DT_RA:   ser_bit = bus.rom_a_s;
            DT_SA:   ser_bit = bus.sram_a_s;
            DT_SD:   ser_bit = bus.sram_d_s;
            default: ser_bit = 1'b0;
        endcase
    end

    assign active    = (state_d != StIdle);
    assign field_chg = (state_d != state_q);

    cle_ser_shift #(
        .Width (MaxW),
        .CntW  (CntW)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .frame_len (frame_len),
        .active    (active),
        .field_chg (field_chg),
        .bit_in    (ser_bit),
        .data      (ser_data),
        .done      (ser_done),
        .abort     (ser_abort)
    );

    // Steer a completed frame into the field it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_a_q      <= '0;
            sram_a_q     <= '0;
            sram_d_q     <= '0;
            rom_a_vld_q  <= 1'b0;
            sram_a_vld_q <= 1'b0;
            sram_d_vld_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            rom_a_vld_q  <= 1'b0;
            sram_a_vld_q <= 1'b0;
            sram_d_vld_q <= 1'b0;
            abort_q      <= ser_abort;
            if (ser_done) begin
                case (state_q)
                    StRxRa: begin
                        rom_a_q     <= ser_data[RA_W-1:0];
                        rom_a_vld_q <= 1'b1;
                    end
                    StRxSa: begin
                        sram_a_q     <= ser_data[SA_W-1:0];
                        sram_a_vld_q <= 1'b1;
                    end
                    StRxSd: begin
                        sram_d_q     <= ser_data[SD_W-1:0];
                        sram_d_vld_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rom_a      = rom_a_q;
    assign bus.sram_a     = sram_a_q;
    assign bus.sram_d     = sram_d_q;
    assign bus.rom_a_vld  = rom_a_vld_q;
    assign bus.sram_a_vld = sram_a_vld_q;
    assign bus.sram_d_vld = sram_d_vld_q;
    assign bus.abort      = abort_q;

`ifdef CLE_DESER_ABORT_CNT_EN
    logic [7:0] abort_cnt_q;

    // Counts alongside the abort pulse register, saturating at 255.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            abort_cnt_q <= '0;
        end else if (ser_abort && (abort_cnt_q != 8'hFF)) begin
            abort_cnt_q <= abort_cnt_q + 8'd1;
        end
    end

    assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_cle_pin_deser.sv
module tb_cle_pin_deser;
    import cle_pin_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cle_pin_deser_if bus ();

`ifdef CLE_DESER_ABORT_CNT_EN
    logic [7:0] abort_cnt;
`endif

    cle_pin_deser dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef CLE_DESER_ABORT_CNT_EN
        ,
        .abort_cnt (abort_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one serial cycle; unselected pins carry the inverted bit so that
    // sampling the wrong pin shows up. Returns 1 time unit after the edge.
    task automatic drive(input logic [1:0] dt, input logic b);
        bus.dtype    = dt;
        bus.rom_a_s  = (dt == DT_RA) ? b : ~b;
        bus.sram_a_s = (dt == DT_SA) ? b : ~b;
        bus.sram_d_s = (dt == DT_SD) ? b : ~b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.dtype    = DT_IDLE;
        bus.rom_a_s  = 1'b0;
        bus.sram_a_s = 1'b0;
        bus.sram_d_s = 1'b0;
        #3;
        checks++;
        if (bus.rom_a !== 7'h00) begin
            errors++; $display("FAIL reset_rom_a: got %h want 00", bus.rom_a);
        end
        checks++;
        if (bus.sram_a !== 10'h000) begin
            errors++; $display("FAIL reset_sram_a: got %h want 000", bus.sram_a);
        end
        checks++;
        if (bus.sram_d !== 8'h00) begin
            errors++; $display("FAIL reset_sram_d: got %h want 00", bus.sram_d);
        end
        checks++;
        if ({bus.rom_a_vld, bus.sram_a_vld, bus.sram_d_vld, bus.abort} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: got %b want 0000",
                     {bus.rom_a_vld, bus.sram_a_vld, bus.sram_d_vld, bus.abort});
        end
`ifdef CLE_DESER_ABORT_CNT_EN
        checks++;
        if (abort_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_abort_cnt: got %0d want 0", abort_cnt);
        end
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(DT_IDLE, 1'b0);
    endtask

    task automatic test_rom_frame();
        logic [6:0] v;
        v = 7'h59;
        for (int i = 6; i >= 0; i--) begin
            drive(DT_RA, v[i]);
            checks++;
            if (bus.rom_a_vld !== 1'b0) begin
                errors++; $display("FAIL rom_early_vld: bit %0d got %b want 0", i, bus.rom_a_vld);
            end
        end
        drive(DT_IDLE, 1'b0);
        checks++;
        if (bus.rom_a_vld !== 1'b1) begin
            errors++; $display("FAIL rom_vld: got %b want 1", bus.rom_a_vld);
        end
        checks++;
        if (bus.rom_a !== 7'h59) begin
            errors++; $display("FAIL rom_a: got %h want 59", bus.rom_a);
        end
        checks++;
        if (bus.abort !== 1'b0) begin
            errors++; $display("FAIL rom_abort: got %b want 0", bus.abort);
        end
        drive(DT_IDLE, 1'b0);
        checks++;
        if (bus.rom_a_vld !== 1'b0 || bus.rom_a !== 7'h59) begin
            errors++;
            $display("FAIL rom_hold: got vld %b val %h want 0 59", bus.rom_a_vld, bus.rom_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] v;
        logic        exp_vld;
        v = {10'h3FF, 10'h001};
        for (int k = 1; k <= 21; k++) begin
            if (k <= 20) drive(DT_SA, v[20-k]);
            else         drive(DT_IDLE, 1'b0);
            exp_vld = (k == 11) || (k == 21);
            checks++;
            if (bus.sram_a_vld !== exp_vld) begin
                errors++;
                $display("FAIL b2b_vld: cycle %0d got %b want %b", k, bus.sram_a_vld, exp_vld);
            end
            checks++;
            if (bus.abort !== 1'b0) begin
                errors++; $display("FAIL b2b_abort: cycle %0d got %b want 0", k, bus.abort);
            end
            if (k == 11) begin
                checks++;
                if (bus.sram_a !== 10'h3FF) begin
                    errors++; $display("FAIL b2b_first: got %h want 3ff", bus.sram_a);
                end
            end
            if (k == 21) begin
                checks++;
                if (bus.sram_a !== 10'h001) begin
                    errors++; $display("FAIL b2b_second: got %h want 001", bus.sram_a);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] d;
        d = 8'hA5;
        for (int i = 7; i >= 0; i--) drive(DT_SD, d[i]);
        drive(DT_IDLE, 1'b0);
        checks++;
        if (bus.sram_d_vld !== 1'b1 || bus.sram_d !== 8'hA5) begin
            errors++;
            $display("FAIL sd_setup: got vld %b val %h want 1 a5", bus.sram_d_vld, bus.sram_d);
        end
        // Partial frame of 4 bits, then idle.
        for (int i = 0; i < 4; i++) drive(DT_SD, i[0]);
        drive(DT_IDLE, 1'b0);
        checks++;
        if (bus.abort !== 1'b1) begin
            errors++; $display("FAIL abort_pulse: got %b want 1", bus.abort);
        end
        checks++;
        if (bus.sram_d_vld !== 1'b0 || bus.sram_d !== 8'hA5) begin
            errors++;
            $display("FAIL abort_hold: got vld %b val %h want 0 a5", bus.sram_d_vld, bus.sram_d);
        end
        drive(DT_IDLE, 1'b0);
        checks++;
        if (bus.abort !== 1'b0) begin
            errors++; $display("FAIL abort_width: got %b want 0", bus.abort);
        end
        // Partial ROM frame cut short by a switch to SRAM data, whose first
        // bit is taken in the switching cycle.
        for (int i = 0; i < 3; i++) drive(DT_RA, 1'b0);
        d = 8'h5A;
        for (int i = 7; i >= 0; i--) begin
            drive(DT_SD, d[i]);
            if (i == 7) begin
                checks++;
                if (bus.abort !== 1'b1 || bus.rom_a !== 7'h59) begin
                    errors++;
                    $display("FAIL switch_abort: got abort %b rom_a %h want 1 59",
                             bus.abort, bus.rom_a);
                end
            end
        end
        drive(DT_IDLE, 1'b0);
        checks++;
        if (bus.sram_d_vld !== 1'b1 || bus.sram_d !== 8'h5A) begin
            errors++;
            $display("FAIL switch_frame: got vld %b val %h want 1 5a", bus.sram_d_vld, bus.sram_d);
        end
        checks++;
        if (bus.rom_a_vld !== 1'b0 || bus.rom_a !== 7'h59) begin
            errors++;
            $display("FAIL switch_rom_hold: got vld %b val %h want 0 59", bus.rom_a_vld, bus.rom_a);
        end
    endtask

    task automatic test_commit_switch();
        logic [7:0] d;
        logic [9:0] a;
        d = 8'h3C;
        a = 10'h2C6;
        for (int i = 7; i >= 0; i--) drive(DT_SD, d[i]);
        for (int i = 9; i >= 0; i--) begin
            drive(DT_SA, a[i]);
            if (i == 9) begin
                checks++;
                if (bus.sram_d_vld !== 1'b1 || bus.sram_d !== 8'h3C) begin
                    errors++;
                    $display("FAIL cs_commit: got vld %b val %h want 1 3c",
                             bus.sram_d_vld, bus.sram_d);
                end
            end else begin
                checks++;
                if (bus.sram_a_vld !== 1'b0) begin
                    errors++; $display("FAIL cs_sa_early: bit %0d got %b want 0", i, bus.sram_a_vld);
                end
            end
            checks++;
            if (bus.abort !== 1'b0) begin
                errors++; $display("FAIL cs_abort: bit %0d got %b want 0", i, bus.abort);
            end
        end
        drive(DT_IDLE, 1'b0);
        checks++;
        if (bus.sram_a_vld !== 1'b1 || bus.sram_a !== 10'h2C6) begin
            errors++;
            $display("FAIL cs_sa_frame: got vld %b val %h want 1 2c6", bus.sram_a_vld, bus.sram_a);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] a;
        a = 10'h0F0;
        for (int i = 9; i >= 5; i--) drive(DT_SA, a[i]);
        // Sixth bit on the pins, reset lands mid-cycle.
        bus.dtype    = DT_SA;
        bus.sram_a_s = a[4];
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.rom_a !== 7'h00 || bus.sram_a !== 10'h000 || bus.sram_d !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_vals: got %h %h %h want 00 000 00",
                     bus.rom_a, bus.sram_a, bus.sram_d);
        end
        checks++;
        if ({bus.rom_a_vld, bus.sram_a_vld, bus.sram_d_vld, bus.abort} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_pulses: got %b want 0000",
                     {bus.rom_a_vld, bus.sram_a_vld, bus.sram_d_vld, bus.abort});
        end
`ifdef CLE_DESER_ABORT_CNT_EN
        checks++;
        if (abort_cnt !== 8'd0) begin
            errors++; $display("FAIL rst_mid_abort_cnt: got %0d want 0", abort_cnt);
        end
`endif
        @(posedge clk);
        #1;
        bus.dtype = DT_IDLE;
        reset     = 1'b1;
        drive(DT_IDLE, 1'b0);
        checks++;
        if ({bus.sram_a_vld, bus.abort} !== 2'b00) begin
            errors++;
            $display("FAIL rst_release: got vld/abort %b want 00", {bus.sram_a_vld, bus.abort});
        end
        a = 10'h155;
        for (int i = 9; i >= 0; i--) drive(DT_SA, a[i]);
        drive(DT_IDLE, 1'b0);
        checks++;
        if (bus.sram_a_vld !== 1'b1 || bus.sram_a !== 10'h155 || bus.abort !== 1'b0) begin
            errors++;
            $display("FAIL rst_frame: got vld %b val %h abort %b want 1 155 0",
                     bus.sram_a_vld, bus.sram_a, bus.abort);
        end
    endtask

`ifdef CLE_DESER_ABORT_CNT_EN
    task automatic test_abort_cnt();
        for (int n = 0; n < 10; n++) begin
            drive(DT_SD, 1'b1);
            drive(DT_IDLE, 1'b0);
        end
        checks++;
        if (abort_cnt !== 8'd10) begin
            errors++; $display("FAIL abort_cnt_10: got %0d want 10", abort_cnt);
        end
        for (int n = 10; n < 300; n++) begin
            drive(DT_SD, 1'b1);
            drive(DT_IDLE, 1'b0);
        end
        checks++;
        if (abort_cnt !== 8'd255) begin
            errors++; $display("FAIL abort_cnt_sat: got %0d want 255", abort_cnt);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rom_frame();
        test_back_to_back();
        test_abort();
        test_commit_switch();
        test_reset_mid();
`ifdef CLE_DESER_ABORT_CNT_EN
        test_abort_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
